// File: rtl/edf_ic_nested.sv
// EDF interrupt controller with nested preemption, claim/complete
// handshake and deadline-miss detection.
module edf_ic_nested #(
    parameter int unsigned NrIrqs    = 8,
    parameter int unsigned TsWidth   = 24,
    parameter int unsigned NestDepth = 4,
    localparam int unsigned IdWidth  = $clog2(NrIrqs),
    localparam int unsigned LvlWidth = $clog2(NestDepth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_req_i,
    input  logic                cfg_we_i,
    input  logic [31:0]         cfg_addr_i,
    input  logic [31:0]         cfg_wdata_i,
    output logic [31:0]         cfg_rdata_o,
    input  logic [63:0]         mtime_i,
    input  logic [NrIrqs-1:0]   irq_i,
    output logic                irq_valid_o,
    output logic [IdWidth-1:0]  irq_id_o,
    output logic [TsWidth-1:0]  irq_dl_o,
    input  logic                irq_claim_i,
    input  logic                irq_complete_i,
    output logic                irq_miss_o,
    output logic [IdWidth-1:0]  miss_id_o,
    output logic [LvlWidth-1:0] nest_lvl_o
);
    localparam int unsigned StkW = (NestDepth > 1) ? $clog2(NestDepth) : 1;
    localparam logic [LvlWidth-1:0] MaxLvl = LvlWidth'(NestDepth);

    function automatic logic earlier(input logic [TsWidth-1:0] a,
                                     input logic [TsWidth-1:0] b);
        logic [TsWidth-1:0] d;
        d = a - b;
        return d[TsWidth-1];
    endfunction

    logic [NrIrqs-1:0]  ie_q, ie_d, ip_q, ip_d, typ_q, typ_d, pol_q, pol_d;
    logic [NrIrqs-1:0]  miss_q, miss_d, ins_q, ins_d, prev_q;
    logic [NrIrqs-1:0]  mpend_q, mpend_d;
    logic [TsWidth-1:0] rel_q [NrIrqs];
    logic [TsWidth-1:0] rel_d [NrIrqs];
    logic [TsWidth-1:0] abs_q [NrIrqs];
    logic [TsWidth-1:0] abs_d [NrIrqs];
    logic [IdWidth-1:0] stk_id_q [NestDepth];
    logic [IdWidth-1:0] stk_id_d [NestDepth];
    logic [TsWidth-1:0] stk_dl_q [NestDepth];
    logic [TsWidth-1:0] stk_dl_d [NestDepth];
    logic [LvlWidth-1:0] lvl_q, lvl_d;
    logic               valid_q, valid_d, mo_q, mo_d;
    logic [IdWidth-1:0] id_q, id_d, mid_q, mid_d, top_id, best_id;
    logic [TsWidth-1:0] dl_q, dl_d, best_dl, top_dl, now, wrel;
    logic [NrIrqs-1:0]  hit, trig, newmiss, mcand, elig;
    logic               wr0, claim_ok, pop_ok, found;
    logic [IdWidth-1:0] widx;

    assign now  = mtime_i[TsWidth-1:0];
    assign wrel = cfg_wdata_i[8 +: TsWidth];
    assign widx = cfg_addr_i[IdWidth+1:2];
    assign wr0  = cfg_req_i & cfg_we_i & ~cfg_addr_i[IdWidth+2];

    logic unused_bits;
    assign unused_bits = ^{mtime_i, cfg_addr_i, cfg_wdata_i};

    always_comb begin
        cfg_rdata_o = '0;
        if (cfg_req_i && !cfg_we_i) begin
            if (!cfg_addr_i[IdWidth+2]) begin
                cfg_rdata_o = {24'(rel_q[widx]), 3'b0, miss_q[widx],
                               pol_q[widx], typ_q[widx], ip_q[widx],
                               ie_q[widx]};
            end else begin
                cfg_rdata_o = 32'(abs_q[widx]);
            end
        end
    end

    always_comb begin
        ie_d = ie_q; ip_d = ip_q; typ_d = typ_q; pol_d = pol_q;
        miss_d = miss_q; ins_d = ins_q;
        rel_d = rel_q; abs_d = abs_q;
        stk_id_d = stk_id_q; stk_dl_d = stk_dl_q; lvl_d = lvl_q;
        hit = '0; trig = '0; newmiss = '0;
        claim_ok = irq_claim_i & valid_q & ~irq_complete_i & (lvl_q < MaxLvl);
        pop_ok = irq_complete_i & (lvl_q != '0);
        top_id = stk_id_q[StkW'(lvl_q - LvlWidth'(1))];
        for (int i = 0; i < NrIrqs; i++) begin
            hit[i] = typ_q[i] ? (pol_q[i] ? (prev_q[i] & ~irq_i[i])
                                          : (irq_i[i] & ~prev_q[i]))
                              : (irq_i[i] ^ pol_q[i]);
            trig[i] = hit[i] & ~ip_q[i] & ~ins_q[i];
            newmiss[i] = (ip_q[i] | ins_q[i]) & ~miss_q[i] &
                         ~earlier(now, abs_q[i]);
            if (newmiss[i]) miss_d[i] = 1'b1;
            if (wr0 && widx == IdWidth'(i)) begin
                rel_d[i] = wrel;
                pol_d[i] = cfg_wdata_i[3];
                typ_d[i] = cfg_wdata_i[2];
                ie_d[i]  = cfg_wdata_i[0];
                ip_d[i]  = cfg_wdata_i[1];
                if (cfg_wdata_i[1]) abs_d[i] = now + wrel;
                if (cfg_wdata_i[4]) miss_d[i] = 1'b0;
            end
            // Hardware trigger uses the stored rel_dl and overrides the write
            if (trig[i]) begin
                ip_d[i]  = 1'b1;
                abs_d[i] = now + rel_q[i];
            end
        end
        if (claim_ok) begin
            ip_d[id_q]  = 1'b0;
            ins_d[id_q] = 1'b1;
            stk_id_d[StkW'(lvl_q)] = id_q;
            stk_dl_d[StkW'(lvl_q)] = dl_q;
            lvl_d = lvl_q + LvlWidth'(1);
        end else if (pop_ok) begin
            ins_d[top_id] = 1'b0;
            lvl_d = lvl_q - LvlWidth'(1);
        end
    end

    always_comb begin
        mcand = mpend_q | newmiss;
        mo_d = 1'b0;
        mid_d = '0;
        for (int i = NrIrqs - 1; i >= 0; i--) begin
            if (mcand[i]) begin
                mo_d  = 1'b1;
                mid_d = IdWidth'(i);
            end
        end
        mpend_d = mcand;
        if (mo_d) mpend_d[mid_d] = 1'b0;
    end

    // Arbitrate against the post-claim/complete stack so a claimed line drops at once
    always_comb begin
        elig = ie_q & ip_q & ~ins_d;
        found = 1'b0;
        best_id = '0;
        best_dl = '0;
        for (int i = 0; i < NrIrqs; i++) begin
            if (elig[i] && (!found || earlier(abs_q[i], best_dl))) begin
                found   = 1'b1;
                best_id = IdWidth'(i);
                best_dl = abs_q[i];
            end
        end
        top_dl = stk_dl_d[StkW'(lvl_d - LvlWidth'(1))];
        valid_d = found && (lvl_d == '0 ||
                  (lvl_d < MaxLvl && earlier(best_dl, top_dl)));
        id_d = best_id;
        dl_d = best_dl;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q <= '0; ip_q <= '0; typ_q <= '0; pol_q <= '0;
            miss_q <= '0; ins_q <= '0; prev_q <= '0; mpend_q <= '0;
            for (int i = 0; i < NrIrqs; i++) begin
                rel_q[i] <= '0;
                abs_q[i] <= '0;
            end
            for (int i = 0; i < NestDepth; i++) begin
                stk_id_q[i] <= '0;
                stk_dl_q[i] <= '0;
            end
            lvl_q <= '0; valid_q <= 1'b0; id_q <= '0; dl_q <= '0;
            mo_q <= 1'b0; mid_q <= '0;
        end else begin
            ie_q <= ie_d; ip_q <= ip_d; typ_q <= typ_d; pol_q <= pol_d;
            miss_q <= miss_d; ins_q <= ins_d; prev_q <= irq_i;
            mpend_q <= mpend_d;
            rel_q <= rel_d; abs_q <= abs_d;
            stk_id_q <= stk_id_d; stk_dl_q <= stk_dl_d;
            lvl_q <= lvl_d; valid_q <= valid_d; id_q <= id_d; dl_q <= dl_d;
            mo_q <= mo_d; mid_q <= mid_d;
        end
    end

    assign irq_valid_o = valid_q;
    assign irq_id_o    = id_q;
    assign irq_dl_o    = dl_q;
    assign irq_miss_o  = mo_q;
    assign miss_id_o   = mid_q;
    assign nest_lvl_o  = lvl_q;
endmodule

// File: doc/edf_ic_nested.md
Name: edf_ic_nested

Overview:
Parametrised successor to the EDF interrupt controller, with three additions: nested preemption, a claim/complete handshake and deadline-miss detection.
- Each line holds a relative deadline. When the line triggers, the block latches an absolute deadline = mtime + relative.
- An in-service stack of depth NestDepth lets a pending line preempt only when its deadline is strictly earlier than the deadline of the interrupt currently being serviced.
- The block sits between the external interrupt sources and the core's interrupt interface, configured over the cfg bus.

Parameters:
- NrIrqs, 8, number of interrupt lines (≥2, power of two); IdWidth = $clog2(NrIrqs) derived.
- TsWidth, 24, width of deadlines and of the time compare (≤24).
- NestDepth, 4, in-service stack depth (≥1); LvlWidth = $clog2(NestDepth+1) derived.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_req_i  in  1  config access strobe, single cycle, always accepted
- cfg_we_i  in  1  1=write, 0=read
- cfg_addr_i  in  32  byte address
- cfg_wdata_i  in  32  write data
- cfg_rdata_o  out  32  combinational read data, 0 when not reading
- mtime_i  in  64  timebase; only [TsWidth-1:0] used
- irq_i  in  NrIrqs  raw interrupt inputs, synchronous to clk_i
- irq_valid_o  out  1  a preempting candidate is available (registered)
- irq_id_o  out  IdWidth  candidate index (registered)
- irq_dl_o  out  TsWidth  candidate absolute deadline (registered)
- irq_claim_i  in  1  core takes the candidate
- irq_complete_i  in  1  core finishes the top-of-stack interrupt
- irq_miss_o  out  1  one-cycle pulse, deadline miss detected
- miss_id_o  out  IdWidth  line index for irq_miss_o
- nest_lvl_o  out  LvlWidth  current stack occupancy

Behaviour:
- Reset: all line state, stack, irq_i history and every output are 0.
- Address map:
  - Word index = cfg_addr_i[IdWidth+1:2]; cfg_addr_i[IdWidth+2] selects the bank.
  - Bank 0 is line config: [31:8] rel_dl, [4] miss (write 1 clears), [3] pol, [2] type (1=edge), [1] ip, [0] ie.
  - Bank 1 is read-only: {8'b0, abs_dl}, zero-extended to 32 bits. Writes to bank 1 are ignored.
- Config write to bank 0:
  - Loads rel_dl, pol, type and ie.
  - Writing ip=1 is a software trigger: sets ip and abs_dl = mtime+rel_dl (new rel_dl). Writing ip=0 clears ip.
- Gateway (irq_i is registered once as irq_prev):
  - Edge mode: a rising edge (pol=0) or falling edge (pol=1) sets ip and latches abs_dl.
  - Level mode: the active level sets ip and latches abs_dl only when ip=0 and the line is not in service.
  - Hardware triggers on a line that is already pending or in service are ignored. Its abs_dl is not reloaded.
- Time arithmetic: all sums are mod 2^TsWidth.
  - earlier(a,b) is true iff the MSB of (a-b) is 1.
  - Equal deadlines tie-break to the lower index.
- Arbitration:
  - A line is eligible when ie & ip & ~in_service.
  - Candidate = eligible line with the earliest abs_dl.
  - The candidate is presented when the stack is empty, or when it is not full and earlier(cand_dl, top_dl) holds (strict).
  - Outputs are registered, so a state change is visible one cycle later.
- Claim:
  - Applies when irq_claim_i & irq_valid_o. Pushes {irq_id_o, irq_dl_o}, clears that line's ip, sets in_service, increments nest_lvl_o.
  - irq_valid_o drops the next cycle unless another line qualifies against the new top.
  - A claim while irq_valid_o=0 is ignored.
- Complete: pops the top entry, clears that line's in_service, decrements nest_lvl_o. A complete on an empty stack is ignored.
- Same-cycle events:
  - claim+complete: complete wins, claim is ignored.
  - A config write and a hardware trigger on the same line: the hardware trigger wins for ip/abs_dl; the write still updates the other fields.
  - A claim and a config write that clears the claimed line's ip: the claim wins.
- Miss detection:
  - A line with (ip | in_service) & ~miss, where mtime[TsWidth-1:0] is not earlier than abs_dl, sets miss.
  - The same cycle it pulses irq_miss_o with the lowest such index; further simultaneous misses pulse on following cycles.
  - miss stays set until cleared by writing 1.
- Reset mid-operation clears the stack and all pending state immediately; no pulse is emitted.

Test Plan:
- Line 2 edge rising, rel=100, mtime=1000 → abs_dl=1100; irq_valid_o=1, id=2, dl=1100 two cycles after the edge; claim → valid=0, nest_lvl=1.
- Lines 1 (rel=300) and 5 (rel=50) trigger together → id=5 presented; claim 5, then 1 is not presented (later deadline); complete → id=1 presented.
- In service line 3 with dl=500, line 6 triggers with dl=400 → preempts, nest_lvl=2; NestDepth=2 full, third earlier line → valid stays 0 until complete.
- mtime near 2^24-10, rel=20 → abs_dl=10 (wrapped); earlier(10, 0xFFFFF0) false and miss not flagged until mtime wraps past 10.
- Pending line 4, dl=2000, never claimed; mtime reaches 2000 → irq_miss_o one-cycle pulse with miss_id_o=4, bank 0 bit4=1; write bit4=1 → cleared.
- Level-mode line, pol=1, held low → single pending; claim/complete while still low → re-pends with fresh abs_dl; claim+complete same cycle → only pop occurs.
